// File: rtl/crypto_pkg.sv
// Shared state encoding and register map for the crypto sequencer.
package crypto_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYGEN = 2'd1,
        ST_ENC    = 2'd2
    } crypto_state_t;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_PT     = 4'h8;
    localparam logic [3:0] OFF_CT     = 4'hC;

    localparam int CTRL_START = 0;
    localparam int CTRL_REKEY = 1;
    localparam int CTRL_CLR   = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_KEYV = 2;
    localparam int STAT_ERR  = 3;

endpackage

// File: rtl/crypto_ctrl_if.sv
// CPU data-bus slice for the CRPT region: word-aligned store strobe and combinational read.
interface crypto_ctrl_if;
    logic        sel;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output addr, output we, output wdata, input rdata);
    modport slave  (input sel, input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/crypto_regs.sv
// Bus decode, key/PT/CT/status register file and read mux for the crypto sequencer.
module crypto_regs
    import crypto_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    crypto_ctrl_if.slave      bus,
    input  logic              busy,
    input  logic              start_go,
    input  logic              key_load,
    input  logic              key_fail,
    input  logic              ct_load,
    input  logic [DATA_W-1:0] trng_data,
    input  logic [DATA_W-1:0] enc_ct,
    output logic              start_cmd,
    output logic              rekey_cmd,
    output logic [DATA_W-1:0] key,
    output logic [DATA_W-1:0] pt,
    output logic              key_valid,
    output logic              done
);

    logic              ctrl_wr;
    logic              pt_wr;
    logic              clr_cmd;
    logic              err;
    logic [DATA_W-1:0] ct;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign ctrl_wr   = bus.sel && bus.we && (bus.addr == OFF_CTRL);
    assign pt_wr     = bus.sel && bus.we && (bus.addr == OFF_PT) && !busy;
    assign start_cmd = ctrl_wr && bus.wdata[CTRL_START];
    assign rekey_cmd = ctrl_wr && bus.wdata[CTRL_REKEY];
    assign clr_cmd   = ctrl_wr && bus.wdata[CTRL_CLR];

    assign unused_wdata = ^bus.wdata[31:DATA_W];

    // A completing cipher outranks CLR; leaving IDLE also wipes stale done/err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pt        <= '0;
            ct        <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (pt_wr)
                pt <= bus.wdata[DATA_W-1:0];
            if (key_load) begin
                key       <= trng_data;
                key_valid <= 1'b1;
            end else if (key_fail) begin
                key_valid <= 1'b0;
            end
            if (ct_load)
                ct <= enc_ct;
            if (ct_load)
                done <= 1'b1;
            else if (clr_cmd || start_go)
                done <= 1'b0;
            if (key_fail)
                err <= 1'b1;
            else if (clr_cmd || start_go)
                err <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (bus.sel) begin
            case (bus.addr)
                OFF_STATUS: begin
                    rd_mux[STAT_BUSY] = busy;
                    rd_mux[STAT_DONE] = done;
                    rd_mux[STAT_KEYV] = key_valid;
                    rd_mux[STAT_ERR]  = err;
                end
                OFF_PT:  rd_mux[DATA_W-1:0] = pt;
                OFF_CT:  rd_mux[DATA_W-1:0] = ct;
                default: rd_mux = '0;
            endcase
        end
    end

    assign bus.rdata = rd_mux;

endmodule

// File: rtl/crypto_ctrl.sv
// Crypto sequencer: TRNG key capture with timeout, then one cipher run per START.
module crypto_ctrl
    import crypto_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int TRNG_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    crypto_ctrl_if.slave      bus,
    input  logic [DATA_W-1:0] trng_data,
    input  logic              trng_ready,
    output logic [DATA_W-1:0] enc_key,
    output logic [DATA_W-1:0] enc_pt,
    output logic              enc_start,
    input  logic              enc_done,
    input  logic [DATA_W-1:0] enc_ct,
    output logic              done_irq
);

    localparam int CNT_W = $clog2(TRNG_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRNG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TRNG_TIMEOUT);

    crypto_state_t     state;
    crypto_state_t     state_n;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              start_cmd;
    logic              rekey_cmd;
    logic              start_go;
    logic              key_load;
    logic              key_fail;
    logic              ct_load;
    logic              enc_entry;
    logic              key_valid;
    logic              done;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] pt;

    assign busy      = (state != ST_IDLE);
    assign done_irq  = done;
    assign enc_entry = (state_n == ST_ENC) && (state != ST_ENC);

    crypto_regs #(.DATA_W(DATA_W)) u_regs (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .start_go  (start_go),
        .key_load  (key_load),
        .key_fail  (key_fail),
        .ct_load   (ct_load),
        .trng_data (trng_data),
        .enc_ct    (enc_ct),
        .start_cmd (start_cmd),
        .rekey_cmd (rekey_cmd),
        .key       (key),
        .pt        (pt),
        .key_valid (key_valid),
        .done      (done)
    );

    always_comb begin
        state_n  = state;
        start_go = 1'b0;
        key_load = 1'b0;
        key_fail = 1'b0;
        ct_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_cmd) begin
                    start_go = 1'b1;
                    state_n  = (key_valid && !rekey_cmd) ? ST_ENC : ST_KEYGEN;
                end
            end
            ST_KEYGEN: begin
                // A sample arriving on the last allowed cycle still counts.
                if (trng_ready) begin
                    key_load = 1'b1;
                    state_n  = ST_ENC;
                end else if (cnt == CNT_LAST) begin
                    key_fail = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            ST_ENC: begin
                if (enc_done) begin
                    ct_load = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            enc_start <= 1'b0;
            enc_key   <= '0;
            enc_pt    <= '0;
        end else begin
            state     <= state_n;
            enc_start <= enc_entry;
            if (state != ST_KEYGEN)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            // Operands are latched once per run so the cipher sees stable inputs.
            if (enc_entry) begin
                enc_key <= key_load ? trng_data : key;
                enc_pt  <= pt;
            end
        end
    end

endmodule

// File: tb/tb_crypto_ctrl.sv
// Scenario bench for crypto_ctrl: expected cipher operands and results flow through queues.
module tb_crypto_ctrl;
    import crypto_pkg::*;

    localparam int DW  = 10;
    localparam int TMO = 8;

    typedef struct packed {
        logic [DW-1:0] key;
        logic [DW-1:0] pt;
    } op_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] trng_data;
    logic          trng_ready;
    logic [DW-1:0] enc_key;
    logic [DW-1:0] enc_pt;
    logic          enc_start;
    logic          enc_done;
    logic [DW-1:0] enc_ct;
    logic          done_irq;

    crypto_ctrl_if bus();

    crypto_ctrl #(.DATA_W(DW), .TRNG_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .trng_data  (trng_data),
        .trng_ready (trng_ready),
        .enc_key    (enc_key),
        .enc_pt     (enc_pt),
        .enc_start  (enc_start),
        .enc_done   (enc_done),
        .enc_ct     (enc_ct),
        .done_irq   (done_irq)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            n_start = 0;
    int            snap;
    op_t           exp_q[$];
    logic [DW-1:0] ct_q[$];
    op_t           exp_op;
    logic [DW-1:0] exp_ct;
    logic [31:0]   rv;

    always @(negedge clk) if (enc_start === 1'b1) n_start++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.rdata;
        bus.sel = 1'b0;
    endtask

    task automatic pulse_trng(input logic [DW-1:0] d);
        trng_data = d; trng_ready = 1'b1;
        @(posedge clk);
        #1;
        trng_ready = 1'b0;
    endtask

    task automatic pulse_done(input logic [DW-1:0] d);
        enc_ct = d; enc_done = 1'b1;
        @(posedge clk);
        #1;
        enc_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.wdata = 32'h0;
        trng_ready = 1'b0; trng_data = '0; enc_done = 1'b0; enc_ct = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({enc_key, enc_pt} !== '0) begin errors++; $display("FAIL reset_operands got %h want 0", {enc_key, enc_pt}); end
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL reset_enc_start got %b want 0", enc_start); end
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL reset_done_irq got %b want 0", done_irq); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", rv); end
        reset = 1'b0;
        tick(1);
        rd(OFF_PT, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_pt got %h want 0", rv); end
        rd(OFF_CT, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_ct got %h want 0", rv); end
    endtask

    task automatic test_cold_start();
        wr(OFF_PT, 32'h2A5);
        rd(OFF_PT, rv);
        checks++; if (rv !== 32'h2A5) begin errors++; $display("FAIL cold_pt_readback got %h want 2a5", rv); end
        bus.sel = 1'b0; bus.addr = OFF_PT;
        #1;
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rdata_unselected got %h want 0", bus.rdata); end
        exp_q.push_back('{key: 10'h155, pt: 10'h2A5});
        wr(OFF_CTRL, 32'h1);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h1) begin errors++; $display("FAIL cold_status_keygen got %h want 1", rv); end
        rd(OFF_CTRL, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL ctrl_reads_zero got %h want 0", rv); end
        tick(2);
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL cold_no_early_start got %b want 0", enc_start); end
        pulse_trng(10'h155);
        checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL cold_enc_start got %b want 1", enc_start); end
        exp_op = exp_q.pop_front();
        checks++; if (enc_key !== exp_op.key) begin errors++; $display("FAIL cold_enc_key got %h want %h", enc_key, exp_op.key); end
        checks++; if (enc_pt !== exp_op.pt) begin errors++; $display("FAIL cold_enc_pt got %h want %h", enc_pt, exp_op.pt); end
        tick(1);
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL cold_start_single got %b want 0", enc_start); end
        ct_q.push_back(10'h3F0);
        pulse_done(10'h3F0);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h6) begin errors++; $display("FAIL cold_status_done got %h want 6", rv); end
        checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL cold_done_irq got %b want 1", done_irq); end
        exp_ct = ct_q.pop_front();
        rd(OFF_CT, rv);
        checks++; if (rv !== {22'h0, exp_ct}) begin errors++; $display("FAIL cold_ct got %h want %h", rv, exp_ct); end
    endtask

    task automatic test_key_reuse();
        wr(OFF_PT, 32'h0F0);
        exp_q.push_back('{key: 10'h155, pt: 10'h0F0});
        wr(OFF_CTRL, 32'h1);
        checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL reuse_enc_start got %b want 1", enc_start); end
        exp_op = exp_q.pop_front();
        checks++; if (enc_key !== exp_op.key) begin errors++; $display("FAIL reuse_enc_key got %h want %h", enc_key, exp_op.key); end
        checks++; if (enc_pt !== exp_op.pt) begin errors++; $display("FAIL reuse_enc_pt got %h want %h", enc_pt, exp_op.pt); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h5) begin errors++; $display("FAIL reuse_status got %h want 5", rv); end
        tick(3);
        ct_q.push_back(10'h0AB);
        pulse_done(10'h0AB);
        exp_ct = ct_q.pop_front();
        rd(OFF_CT, rv);
        checks++; if (rv !== {22'h0, exp_ct}) begin errors++; $display("FAIL reuse_ct got %h want %h", rv, exp_ct); end
    endtask

    task automatic test_busy_protect();
        wr(OFF_PT, 32'h111);
        exp_q.push_back('{key: 10'h155, pt: 10'h111});
        wr(OFF_CTRL, 32'h1);
        checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL busy_enc_start got %b want 1", enc_start); end
        exp_op = exp_q.pop_front();
        checks++; if (enc_pt !== exp_op.pt) begin errors++; $display("FAIL busy_enc_pt got %h want %h", enc_pt, exp_op.pt); end
        tick(1);
        snap = n_start;
        wr(OFF_PT, 32'h001);
        wr(OFF_CTRL, 32'h1);
        tick(2);
        checks++; if (n_start != snap) begin errors++; $display("FAIL busy_second_start got %0d want %0d", n_start, snap); end
        checks++; if (enc_pt !== 10'h111) begin errors++; $display("FAIL busy_enc_pt_held got %h want 111", enc_pt); end
        rd(OFF_PT, rv);
        checks++; if (rv !== 32'h111) begin errors++; $display("FAIL busy_pt_ignored got %h want 111", rv); end
        ct_q.push_back(10'h222);
        pulse_done(10'h222);
        tick(2);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h6) begin errors++; $display("FAIL busy_status_after got %h want 6", rv); end
        checks++; if (n_start != snap) begin errors++; $display("FAIL busy_no_deferred_start got %0d want %0d", n_start, snap); end
        exp_ct = ct_q.pop_front();
        rd(OFF_CT, rv);
        checks++; if (rv !== {22'h0, exp_ct}) begin errors++; $display("FAIL busy_ct got %h want %h", rv, exp_ct); end
    endtask

    task automatic test_timeout();
        wr(OFF_CTRL, 32'h3);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h5) begin errors++; $display("FAIL tmo_status_start got %h want 5", rv); end
        tick(TMO - 1);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h5) begin errors++; $display("FAIL tmo_status_last_wait got %h want 5", rv); end
        tick(1);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h8) begin errors++; $display("FAIL tmo_status_err got %h want 8", rv); end
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL tmo_no_enc_start got %b want 0", enc_start); end
        wr(OFF_CTRL, 32'h4);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL tmo_clr got %h want 0", rv); end
    endtask

    task automatic test_collisions();
        exp_q.push_back('{key: 10'h0C3, pt: 10'h111});
        wr(OFF_CTRL, 32'h1);
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h1) begin errors++; $display("FAIL col_status_keygen got %h want 1", rv); end
        tick(TMO - 1);
        pulse_trng(10'h0C3);
        checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL col_ready_wins_start got %b want 1", enc_start); end
        exp_op = exp_q.pop_front();
        checks++; if (enc_key !== exp_op.key) begin errors++; $display("FAIL col_enc_key got %h want %h", enc_key, exp_op.key); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h5) begin errors++; $display("FAIL col_ready_wins_status got %h want 5", rv); end
        tick(1);
        ct_q.push_back(10'h3C3);
        enc_ct = 10'h3C3; enc_done = 1'b1;
        wr(OFF_CTRL, 32'h4);
        enc_done = 1'b0;
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h6) begin errors++; $display("FAIL col_done_beats_clr got %h want 6", rv); end
        exp_ct = ct_q.pop_front();
        rd(OFF_CT, rv);
        checks++; if (rv !== {22'h0, exp_ct}) begin errors++; $display("FAIL col_ct got %h want %h", rv, exp_ct); end
        pulse_done(10'h1FF);
        rd(OFF_CT, rv);
        checks++; if (rv !== {22'h0, exp_ct}) begin errors++; $display("FAIL col_stray_done_ct got %h want %h", rv, exp_ct); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h6) begin errors++; $display("FAIL col_stray_done_status got %h want 6", rv); end
        exp_q.push_back('{key: 10'h0C3, pt: 10'h111});
        wr(OFF_CTRL, 32'h5);
        checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL col_clr_start_enc got %b want 1", enc_start); end
        exp_op = exp_q.pop_front();
        checks++; if ({enc_key, enc_pt} !== {exp_op.key, exp_op.pt}) begin errors++; $display("FAIL col_clr_start_ops got %h want %h", {enc_key, enc_pt}, {exp_op.key, exp_op.pt}); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h5) begin errors++; $display("FAIL col_clr_start_status got %h want 5", rv); end
    endtask

    task automatic test_reset_mid_enc();
        #1;
        reset = 1'b1;
        #1;
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL rst_enc_start got %b want 0", enc_start); end
        checks++; if ({enc_key, enc_pt} !== '0) begin errors++; $display("FAIL rst_operands got %h want 0", {enc_key, enc_pt}); end
        checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL rst_done_irq got %b want 0", done_irq); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rst_status got %h want 0", rv); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(OFF_PT, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rst_pt got %h want 0", rv); end
        wr(OFF_PT, 32'h3FF);
        exp_q.push_back('{key: 10'h2AA, pt: 10'h3FF});
        wr(OFF_CTRL, 32'h1);
        checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL rst_rekeys_no_start got %b want 0", enc_start); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h1) begin errors++; $display("FAIL rst_rekeys_status got %h want 1", rv); end
        tick(1);
        pulse_trng(10'h2AA);
        checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL rst_enc_start_after got %b want 1", enc_start); end
        exp_op = exp_q.pop_front();
        checks++; if ({enc_key, enc_pt} !== {exp_op.key, exp_op.pt}) begin errors++; $display("FAIL rst_ops_after got %h want %h", {enc_key, enc_pt}, {exp_op.key, exp_op.pt}); end
        tick(1);
        ct_q.push_back(10'h011);
        pulse_done(10'h011);
        exp_ct = ct_q.pop_front();
        rd(OFF_CT, rv);
        checks++; if (rv !== {22'h0, exp_ct}) begin errors++; $display("FAIL rst_ct_after got %h want %h", rv, exp_ct); end
        rd(OFF_STATUS, rv);
        checks++; if (rv !== 32'h6) begin errors++; $display("FAIL rst_status_after got %h want 6", rv); end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_key_reuse();
        test_busy_protect();
        test_timeout();
        test_collisions();
        test_reset_mid_enc();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crypto_ctrl.md
# crypto_ctrl

Memory-mapped sequencer for the crypto subsystem: owns the key, plaintext and ciphertext registers and sequences TRNG key capture followed by one cipher operation per software START command. Sits between the CPU data bus (CRPT address region, 0x0000_0200) and the `trng`/cipher units, replacing ad-hoc register writes in the top level with a single status-reporting controller.

## Interface
Parameters:
- `DATA_W`, 10, width of key, plaintext and ciphertext.
- `TRNG_TIMEOUT`, 1023, maximum KEYGEN wait in cycles before the error state.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `sel`  in  1  CRPT region decode (addr[9]).
- `addr`  in  4  byte offset within region (addr[3:0]); word aligned.
- `we`  in  1  store strobe (memwrite & sel).
- `wdata`  in  32  store data.
- `rdata`  out  32  combinational read data; 0 when `!sel` or unmapped.
- `trng_data`  in  DATA_W  TRNG output.
- `trng_ready`  in  1  TRNG sample valid, single-cycle.
- `enc_key`, `enc_pt`  out  DATA_W  cipher operands; held stable during ENC.
- `enc_start`  out  1  one-cycle cipher start pulse.
- `enc_done`  in  1  cipher result valid, single-cycle.
- `enc_ct`  in  DATA_W  cipher result.
- `done_irq`  out  1  level, mirrors STATUS.done (for LEDR).

## Operation
Register map (offsets):
- 0x0 CTRL, write-only: bit0 START, bit1 REKEY, bit2 CLR. Reads return 0.
- 0x4 STATUS, read-only: bit0 busy, bit1 done, bit2 key_valid, bit3 err; upper bits 0.
- 0x8 PT, read/write: low DATA_W bits.
- 0xC CT, read-only: low DATA_W bits. The key is never readable.

FSM states: IDLE, KEYGEN, ENC.
- IDLE: START with key_valid=1 and REKEY=0 -> ENC; START with key_valid=0 or REKEY=1 -> KEYGEN. Either transition clears done and err.
- KEYGEN: timeout counter increments each cycle. trng_ready -> capture `trng_data` into key, key_valid=1, go to ENC. Counter reaching TRNG_TIMEOUT without trng_ready -> err=1, key_valid=0, go to IDLE.
- ENC: `enc_start`=1 on the first ENC cycle only. On `enc_done`, capture `enc_ct` into CT, set done=1, go to IDLE.
- busy=1 in KEYGEN and ENC.
- CLR clears done and err. It acts in any state.
- Writes to PT and START while busy are ignored. CLR is still honoured while busy.

Reset: state IDLE; key, PT, CT, `enc_key`, `enc_pt` = 0; `enc_start`=0; busy, done, err, key_valid = 0; `done_irq`=0. Reset asserted mid-operation aborts the operation. The key is discarded, and the next START re-keys.

## Timing
- Register writes take effect at the clock edge that samples `we`. Readback is valid the next cycle.
- START written at edge t: state changes at t, busy=1 from t+1.
- `enc_start` is registered. It is high during the first cycle in ENC.
- The key-valid, no-rekey path asserts `enc_start` the cycle after the START write.
- The KEYGEN path asserts `enc_start` the cycle after `trng_ready`.
- `enc_key`/`enc_pt` are updated only on ENC entry. They are constant until the next ENC entry.
- `enc_done` at edge u: CT, done=1, busy=0 and IDLE are all visible from u+1.
- Simultaneous events:
  - `trng_ready` on the timeout cycle: ready wins, no err.
  - `enc_done` together with CLR: done set wins.
  - `enc_done` outside ENC: ignored.
  - START and CLR in the same write: CLR is applied first, then START is evaluated.
- Timeout counter: width $clog2(TRNG_TIMEOUT+1). It resets to 0 on KEYGEN entry and never wraps.

## Structure
- Shared package `crypto_pkg`:
  - state enum `crypto_state_t`;
  - register offset localparams (CTRL/STATUS/PT/CT);
  - CTRL/STATUS bit indices.
- One natural sub-module, `crypto_regs`: bus decode, register file and read mux.
- The FSM and timeout counter stay in `crypto_ctrl`.

## Test plan
- Cold start: reset, write PT=0x2A5, write CTRL=0x1.
  - STATUS=0x1 (busy).
  - `trng_ready` with data 0x155 -> `enc_start` pulse one cycle later with `enc_key`=0x155, `enc_pt`=0x2A5.
  - `enc_done` with ct=0x3F0 -> CT reads 0x3F0, STATUS=0x6, `done_irq`=1.
- Key reuse: second START without REKEY -> `enc_start` the next cycle, no TRNG wait, `enc_key` still 0x155.
- Timeout: TRNG_TIMEOUT=8, START with REKEY, hold `trng_ready` low -> after 8 cycles STATUS=0x8 (err, key_valid=0). Write CTRL=0x4 -> STATUS=0x0.
- Busy protection: during ENC write PT=0x001 and START=1 -> `enc_pt` is unchanged, PT still reads the old value, and no second `enc_start` occurs.
- Collisions: `enc_done` coincident with a CLR write -> done=1 afterwards. `trng_ready` on the timeout cycle -> err=0, ENC entered.
- Reset mid-ENC: assert reset asynchronously -> all outputs 0 immediately, key_valid=0. The next START goes through KEYGEN.
